// File: rtl/sdm_mod_if.sv
// PCM sample handshake between a sample producer (master) and the sigma-delta modulator (slave).
interface sdm_mod_if #(
  parameter int DATA_W = 16
);
  logic signed [DATA_W-1:0] sample_in;
  logic                     sample_valid;
  logic                     sample_ready;

  modport master (output sample_in, output sample_valid, input  sample_ready);
  modport slave  (input  sample_in, input  sample_valid, output sample_ready);
endinterface

// File: rtl/sdm_mod.sv
// Second-order sigma-delta modulator: signed PCM in, 1-bit stream plus bit clock out.
// One-deep sample buffer feeds the loop once every reg_modosr+1 bits.
module sdm_mod #(
  parameter int DATA_W = 16,
  parameter int INT_W  = 20
) (
  input  logic       SYSCLK,
  input  logic       SYSRSTn,
  input  logic       reg_moden,
  input  logic [7:0] reg_clkdiv,
  input  logic [7:0] reg_modosr,
  input  logic       reg_order,
  sdm_mod_if.slave   smp,
  output logic       sd_clk_out,
  output logic       sd_dsd_out,
  output logic       mod_underrun,
  output logic       sample_strobe
);
  localparam int SUM_W = INT_W + 2;
  localparam logic signed [SUM_W-1:0] FS  = {{(SUM_W-DATA_W){1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] NFS = -FS;
  localparam logic signed [SUM_W-1:0] HI  = {3'b000, {(INT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] LO  = {3'b111, {(INT_W-1){1'b0}}};

  function automatic logic signed [SUM_W-1:0] ext_int(input logic signed [INT_W-1:0] v);
    return {{2{v[INT_W-1]}}, v};
  endfunction

  function automatic logic signed [INT_W-1:0] sat_int(input logic signed [SUM_W-1:0] v);
    logic signed [SUM_W-1:0] c;
    if (v > HI)      c = HI;
    else if (v < LO) c = LO;
    else             c = v;
    return c[INT_W-1:0];
  endfunction

  logic [7:0]               r_div;
  logic                     r_sdclk;
  logic                     r_dsd;
  logic [7:0]               r_osr;
  logic signed [INT_W-1:0]  r_i1;
  logic signed [INT_W-1:0]  r_i2;
  logic signed [DATA_W-1:0] r_active;
  logic signed [DATA_W-1:0] r_buf;
  logic                     r_buf_full;
  logic                     r_ready;
  logic                     r_underrun;
  logic                     r_strobe;

  logic signed [SUM_W-1:0]  w_x;
  logic signed [SUM_W-1:0]  w_fb;
  logic signed [SUM_W-1:0]  w_sum1;
  logic signed [SUM_W-1:0]  w_sum2;
  logic signed [INT_W-1:0]  w_i1_nxt;
  logic signed [INT_W-1:0]  w_i2_nxt;
  logic                     w_y;
  logic                     w_tick;
  logic                     w_step;
  logic                     w_slot;
  logic                     w_accept;

  // Loop arithmetic: feedback uses the previously emitted bit
  assign w_x      = {{(SUM_W-DATA_W){r_active[DATA_W-1]}}, r_active};
  assign w_fb     = r_dsd ? FS : NFS;
  assign w_sum1   = ext_int(r_i1) + w_x - w_fb;
  assign w_i1_nxt = sat_int(w_sum1);
  assign w_sum2   = ext_int(r_i2) + ext_int(w_i1_nxt) - w_fb;
  assign w_i2_nxt = sat_int(w_sum2);
  assign w_y      = reg_order ? ~w_i2_nxt[INT_W-1] : ~w_i1_nxt[INT_W-1];

  // A step happens only on the tick that takes sd_clk_out from 1 to 0
  assign w_tick   = (r_div == reg_clkdiv);
  assign w_step   = w_tick & r_sdclk;
  assign w_slot   = w_step & (r_osr == reg_modosr);
  assign w_accept = smp.sample_valid & r_ready;

  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      r_div      <= '0;
      r_sdclk    <= 1'b0;
      r_dsd      <= 1'b0;
      r_osr      <= '0;
      r_i1       <= '0;
      r_i2       <= '0;
      r_active   <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_ready    <= 1'b0;
      r_underrun <= 1'b0;
      r_strobe   <= 1'b0;
    end else if (!reg_moden) begin
      r_div      <= '0;
      r_sdclk    <= 1'b0;
      r_dsd      <= 1'b0;
      r_osr      <= '0;
      r_i1       <= '0;
      r_i2       <= '0;
      r_active   <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_ready    <= 1'b0;
      r_underrun <= 1'b0;
      r_strobe   <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_div    <= w_tick ? 8'd0 : r_div + 8'd1;
      if (w_tick) r_sdclk <= ~r_sdclk;
      if (w_step) begin
        r_i1  <= w_i1_nxt;
        r_i2  <= reg_order ? w_i2_nxt : '0;
        r_dsd <= w_y;
        r_osr <= w_slot ? 8'd0 : r_osr + 8'd1;
      end
      // The load sees the buffer state from before any same-cycle accept
      if (w_slot) begin
        if (r_buf_full) begin
          r_active <= r_buf;
          r_strobe <= 1'b1;
        end else begin
          r_underrun <= 1'b1;
        end
      end
      if (w_accept) r_buf <= smp.sample_in;
      if (w_slot && r_buf_full) r_buf_full <= 1'b0;
      else if (w_accept)        r_buf_full <= 1'b1;
      r_ready <= ~((r_buf_full & ~w_slot) | w_accept);
    end
  end

  assign sd_clk_out       = r_sdclk;
  assign sd_dsd_out       = r_dsd;
  assign mod_underrun     = r_underrun;
  assign sample_strobe    = r_strobe;
  assign smp.sample_ready = r_ready;

endmodule
